periph_hex_key_slave: RTL and testbench

- Memory-mapped responder on the core's data-memory interface for the peripheral window starting at ADDRESS_PER.
- Serves three 32-bit registers: CTRL at ADDRESS_PER, HEX at ADDRESS_HEX and KEY at ADDRESS_KEY.
- Drives active-low 7-segment displays from HEX.
- Synchronises, debounces and edge-captures active-low push-buttons into KEY.
- Sits beside the data RAM; the top level routes a request here when data_addr_i >= ADDRESS_PER.

---
 rtl/periph_hex_key_slave_pkg.sv | 32 +++
 rtl/periph_hex_key_slave_hex_to_7seg.sv | 30 +++
 rtl/periph_hex_key_slave.sv | 139 +++++++++++++
 tb/tb_periph_hex_key_slave.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/periph_hex_key_slave_pkg.sv
// rtl/periph_hex_key_slave_pkg.sv - address map, field positions and decode helper for the hex/key peripheral
package periph_hex_key_slave_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] ADDRESS_PER  = 32'h8000_0000;
    localparam logic [XLEN-1:0] ADDRESS_CTRL = ADDRESS_PER;
    localparam logic [XLEN-1:0] ADDRESS_HEX  = ADDRESS_PER + 32'h4;
    localparam logic [XLEN-1:0] ADDRESS_KEY  = ADDRESS_PER + 32'h8;

    localparam int KEY_EDGE_LSB    = 16;
    localparam int CTRL_HEX_EN_BIT = 0;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_ZERO  = 7'h40;

    typedef enum logic [1:0] {
        SEL_NONE,
        SEL_CTRL,
        SEL_HEX,
        SEL_KEY
    } reg_sel_e;

    // Full-width compare: aliases inside the window are deliberately unmapped.
    function automatic reg_sel_e decode_addr(input logic [XLEN-1:0] addr);
        if (addr == ADDRESS_CTRL)     return SEL_CTRL;
        else if (addr == ADDRESS_HEX) return SEL_HEX;
        else if (addr == ADDRESS_KEY) return SEL_KEY;
        else                          return SEL_NONE;
    endfunction

endpackage

// File: rtl/periph_hex_key_slave_hex_to_7seg.sv
// rtl/periph_hex_key_slave_hex_to_7seg.sv - combinational nibble to active-low gfedcba segment decoder
module hex_to_7seg (
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = 7'h7F;
        case (nibble)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            4'hF: seg = 7'h0E;
            default: seg = 7'h7F;
        endcase
    end

endmodule

// File: rtl/periph_hex_key_slave.sv
// rtl/periph_hex_key_slave.sv - data-bus responder for CTRL/HEX/KEY registers, 7-seg drive and key debounce
module periph_hex_key_slave
    import periph_hex_key_slave_pkg::*;
#(
    parameter int HEX_DIGITS      = 6,
    parameter int KEY_NUM         = 4,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    data_req_i,
    input  logic                    data_we_i,
    input  logic [3:0]              data_be_i,
    input  logic [XLEN-1:0]         data_addr_i,
    input  logic [XLEN-1:0]         data_wdata_i,
    output logic                    data_rvalid_o,
    output logic [XLEN-1:0]         data_rdata_o,
    output logic [7*HEX_DIGITS-1:0] hex_o,
    input  logic [KEY_NUM-1:0]      key_i
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);

    reg_sel_e          sel;
    logic              wr;
    logic              hex_en_q;
    logic              hex_en_next;
    logic [XLEN-1:0]   hex_q;
    logic [XLEN-1:0]   hex_next;
    logic [XLEN-1:0]   rd_word;
    logic [XLEN-1:0]   key_word;
    logic [KEY_NUM-1:0] key_level;
    logic [KEY_NUM-1:0] key_edge;
    logic [7*HEX_DIGITS-1:0] seg_next;

    assign sel = decode_addr(data_addr_i);
    assign wr  = data_req_i & data_we_i;

    always_comb begin
        hex_en_next = hex_en_q;
        hex_next    = hex_q;
        if (wr && sel == SEL_CTRL && data_be_i[0])
            hex_en_next = data_wdata_i[CTRL_HEX_EN_BIT];
        if (wr && sel == SEL_HEX) begin
            for (int b = 0; b < 4; b++) begin
                if (data_be_i[b])
                    hex_next[8*b +: 8] = data_wdata_i[8*b +: 8];
            end
        end
    end

    always_comb begin
        key_word = '0;
        key_word[KEY_NUM-1:0] = key_level;
        key_word[KEY_EDGE_LSB +: KEY_NUM] = key_edge;
        rd_word = '0;
        case (sel)
            SEL_CTRL: rd_word[CTRL_HEX_EN_BIT] = hex_en_q;
            SEL_HEX:  rd_word = hex_q;
            SEL_KEY:  rd_word = key_word;
            default:  rd_word = '0;
        endcase
    end

    // Segments are decoded from the next-state values so the display moves with the response.
    for (genvar d = 0; d < HEX_DIGITS; d++) begin : g_digit
        logic [6:0] seg;
        hex_to_7seg u_dec (
            .nibble (hex_next[4*d +: 4]),
            .seg    (seg)
        );
        assign seg_next[7*d +: 7] = hex_en_next ? seg : SEG_BLANK;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_rvalid_o <= 1'b0;
            data_rdata_o  <= '0;
            hex_en_q      <= 1'b1;
            hex_q         <= '0;
            hex_o         <= {HEX_DIGITS{SEG_ZERO}};
        end else begin
            data_rvalid_o <= data_req_i;
            data_rdata_o  <= (data_req_i && !data_we_i) ? rd_word : '0;
            hex_en_q      <= hex_en_next;
            hex_q         <= hex_next;
            hex_o         <= seg_next;
        end
    end

    for (genvar k = 0; k < KEY_NUM; k++) begin : g_key
        localparam int BE_IDX = 2 + k / 8;
        logic             sync1;
        logic             sync2;
        logic             stable;
        logic             edge_flag;
        logic [CNT_W-1:0] cnt;
        logic             pressed;
        logic             accept;
        logic             set_edge;
        logic             clr_edge;

        assign pressed  = ~sync2;
        assign accept   = (pressed != stable) && (cnt == CNT_W'(DEBOUNCE_CYCLES - 1));
        assign set_edge = accept && pressed;
        assign clr_edge = wr && (sel == SEL_KEY) && data_be_i[BE_IDX]
                          && data_wdata_i[KEY_EDGE_LSB + k];

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                sync1     <= 1'b1;
                sync2     <= 1'b1;
                stable    <= 1'b0;
                edge_flag <= 1'b0;
                cnt       <= '0;
            end else begin
                sync1 <= key_i[k];
                sync2 <= sync1;
                if (pressed == stable) begin
                    cnt <= '0;
                end else if (accept) begin
                    stable <= pressed;
                    cnt    <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                // A new press outranks a same-cycle clear so no press is ever lost.
                if (set_edge)
                    edge_flag <= 1'b1;
                else if (clr_edge)
                    edge_flag <= 1'b0;
            end
        end

        assign key_level[k] = stable;
        assign key_edge[k]  = edge_flag;
    end

endmodule

// File: tb/tb_periph_hex_key_slave.sv
// tb/tb_periph_hex_key_slave.sv - scoreboard bench for periph_hex_key_slave
module tb_periph_hex_key_slave;
    import periph_hex_key_slave_pkg::*;

    localparam int HD  = 6;
    localparam int KN  = 4;
    localparam int DEB = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic            req;
    logic            we;
    logic [3:0]      be;
    logic [31:0]     addr;
    logic [31:0]     wdata;
    logic            rvalid;
    logic [31:0]     rdata;
    logic [7*HD-1:0] hex;
    logic [KN-1:0]   key;

    int n_vec = 0;
    int n_bad = 0;
    logic [31:0] exp_q[$];
    string       name_q[$];
    logic        prev_ok = 1'b0;

    periph_hex_key_slave #(
        .HEX_DIGITS      (HD),
        .KEY_NUM         (KN),
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .data_req_i    (req),
        .data_we_i     (we),
        .data_be_i     (be),
        .data_addr_i   (addr),
        .data_wdata_i  (wdata),
        .data_rvalid_o (rvalid),
        .data_rdata_o  (rdata),
        .hex_o         (hex),
        .key_i         (key)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic bus(input logic w, input logic [3:0] b, input logic [31:0] a,
                       input logic [31:0] d, input logic [31:0] e, input string nm);
        @(posedge clk); #1;
        req = 1'b1; we = w; be = b; addr = a; wdata = d;
        exp_q.push_back(w ? 32'h0 : e);
        name_q.push_back(nm);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            req = 1'b0; we = 1'b0; be = 4'h0; addr = '0; wdata = '0;
        end
    endtask

    // Monitor: rvalid must follow each accepted request by one cycle; rdata matches queue head.
    always @(negedge clk) begin
        if (rvalid || prev_ok)
            check("rvalid_timing", {63'h0, rvalid}, {63'h0, prev_ok});
        if (rvalid) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_rvalid: got rdata %h expected no response", rdata);
            end else begin
                check(name_q.pop_front(), {32'h0, rdata}, {32'h0, exp_q.pop_front()});
            end
        end
        prev_ok = req && !rst;
    end

    initial begin
        rst = 1'b1; req = 1'b0; we = 1'b0; be = 4'h0; addr = '0; wdata = '0; key = '1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("reset_hex_o", hex, {6{7'h40}});

        bus(0, 4'h0, ADDRESS_CTRL, 0, 32'h1, "rd_ctrl_reset");
        bus(0, 4'h0, ADDRESS_HEX,  0, 32'h0, "rd_hex_reset");
        bus(0, 4'h0, ADDRESS_KEY,  0, 32'h0, "rd_key_reset");
        idle(1);

        bus(1, 4'hF, ADDRESS_HEX, 32'h0012_34AB, 0, "wr_hex_full");
        idle(1);
        check("hex_o_full", hex, {7'h79, 7'h24, 7'h30, 7'h19, 7'h08, 7'h03});
        bus(0, 4'h0, ADDRESS_HEX, 0, 32'h0012_34AB, "rd_hex_full");
        bus(1, 4'b0010, ADDRESS_HEX, 32'hFFFF_FFFF, 0, "wr_hex_byte1");
        bus(0, 4'h0, ADDRESS_HEX, 0, 32'h0012_FFAB, "rd_hex_byte1");
        idle(1);
        check("hex_o_byte1", hex, {7'h79, 7'h24, 7'h0E, 7'h0E, 7'h08, 7'h03});

        bus(1, 4'h1, ADDRESS_CTRL, 32'h0, 0, "wr_ctrl_off");
        idle(1);
        check("hex_o_blank", hex, {6{7'h7F}});
        bus(0, 4'h0, ADDRESS_CTRL, 0, 32'h0, "rd_ctrl_off");
        bus(1, 4'h1, ADDRESS_CTRL, 32'hFFFF_FFFF, 0, "wr_ctrl_on");
        idle(1);
        check("hex_o_on", hex, {7'h79, 7'h24, 7'h0E, 7'h0E, 7'h08, 7'h03});
        bus(0, 4'h0, ADDRESS_CTRL, 0, 32'h1, "rd_ctrl_on");

        bus(0, 4'h0, 32'h8000_000C, 0, 32'h0, "rd_unmapped");
        bus(1, 4'hF, 32'h8000_000C, 32'hFFFF_FFFF, 0, "wr_unmapped");
        bus(1, 4'h0, ADDRESS_HEX, 32'h0, 0, "wr_hex_be0");
        bus(0, 4'h0, ADDRESS_HEX, 0, 32'h0012_FFAB, "rd_hex_after_ignored");
        bus(0, 4'h0, ADDRESS_CTRL, 0, 32'h1, "rd_ctrl_after_ignored");
        idle(1);

        key[1] = 1'b0;
        idle(5);
        key[1] = 1'b1;
        idle(15);
        bus(0, 4'h0, ADDRESS_KEY, 0, 32'h0, "rd_key_glitch");
        idle(1);
        key[1] = 1'b0;
        idle(20);
        bus(0, 4'h0, ADDRESS_KEY, 0, 32'h0002_0002, "rd_key_pressed");
        idle(1);
        key[1] = 1'b1;
        idle(20);
        bus(0, 4'h0, ADDRESS_KEY, 0, 32'h0002_0000, "rd_key_released");
        idle(1);

        // Press lands after 8 idles; the W1C is captured on the same edge the press is accepted.
        key[1] = 1'b0;
        idle(8);
        bus(1, 4'b0100, ADDRESS_KEY, 32'h0002_0000, 0, "w1c_with_edge");
        bus(0, 4'h0, ADDRESS_KEY, 0, 32'h0002_0002, "rd_key_set_wins");
        bus(1, 4'b0100, ADDRESS_KEY, 32'h0002_0000, 0, "w1c_plain");
        bus(0, 4'h0, ADDRESS_KEY, 0, 32'h0000_0002, "rd_key_cleared");
        idle(1);
        key[1] = 1'b1;
        idle(20);
        bus(0, 4'h0, ADDRESS_KEY, 0, 32'h0, "rd_key_idle");

        bus(1, 4'h1, ADDRESS_CTRL, 32'h0, 0, "wr_ctrl_pre_reset");
        bus(0, 4'h0, ADDRESS_HEX, 0, 32'h0012_FFAB, "rd_before_reset");
        @(posedge clk); #1;
        req = 1'b1; we = 1'b0; addr = ADDRESS_CTRL; rst = 1'b1;
        @(posedge clk); #1;
        addr = ADDRESS_HEX;
        @(posedge clk); #1;
        rst = 1'b0; req = 1'b0; addr = '0;
        check("hex_o_after_reset", hex, {6{7'h40}});
        bus(0, 4'h0, ADDRESS_CTRL, 0, 32'h1, "rd_ctrl_after_reset");
        bus(0, 4'h0, ADDRESS_HEX,  0, 32'h0, "rd_hex_after_reset");
        bus(0, 4'h0, ADDRESS_KEY,  0, 32'h0, "rd_key_after_reset");
        idle(3);
        check("scoreboard_drained", 64'(exp_q.size()), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
